// File: rtl/snake_disp_pkg.sv
// Shared definitions for the snake display path: mode codes, draw FSM states and
// coordinate field helpers.
package snake_disp_pkg;

   localparam logic [1:0] MODE_GAME  = 2'b00;
   localparam logic [1:0] MODE_START = 2'b01;
   localparam logic [1:0] MODE_OVER  = 2'b10;
   localparam logic [1:0] MODE_WIN   = 2'b11;

   // Widest coordinate field supported (GRID up to 32).
   localparam int MAX_CW = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FOOD,
      ST_SEG,
      ST_SWAP
   } draw_state_t;

   // A coordinate packs {row, col}, each cw bits wide; callers zero-extend to 2*MAX_CW.
   function automatic logic [MAX_CW-1:0] coord_row(input logic [2*MAX_CW-1:0] coord,
                                                   input int cw);
      logic [2*MAX_CW-1:0] mask;
      mask = (2*MAX_CW)'((1 << cw) - 1);
      return MAX_CW'((coord >> cw) & mask);
   endfunction

   function automatic logic [MAX_CW-1:0] coord_col(input logic [2*MAX_CW-1:0] coord,
                                                   input int cw);
      logic [2*MAX_CW-1:0] mask;
      mask = (2*MAX_CW)'((1 << cw) - 1);
      return MAX_CW'(coord & mask);
   endfunction

endpackage

// File: rtl/led_row_scanner.sv
// Row scan timing for the LED matrix: holds each row for SCAN_DIV clocks and
// drives a registered one-hot row strobe.
module led_row_scanner #(
   parameter int GRID     = 16,
   parameter int CW       = $clog2(GRID),
   parameter int SCAN_DIV = 4
) (
   input  logic            clk,
   input  logic            reset,
   output logic [CW-1:0]   row_idx,
   output logic [GRID-1:0] row_sel
);

   localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [SCW-1:0] scan_cnt;

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt <= '0;
         row_idx  <= '0;
         row_sel  <= '0;
      end else begin
         row_sel <= GRID'(1) << row_idx;
         if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            row_idx  <= row_idx + CW'(1);
         end else begin
            scan_cnt <= scan_cnt + SCW'(1);
         end
      end
   end

endmodule

// File: rtl/snake_frame_renderer.sv
// Double-buffered snake/food rasteriser with a sequential draw engine and a
// row-scanned LED output with mode overlays.
module snake_frame_renderer
   import snake_disp_pkg::*;
#(
   parameter int GRID     = 16,
   parameter int CW       = $clog2(GRID),
   parameter int MAX_LEN  = 10,
   parameter int LW       = $clog2(MAX_LEN + 1),
   parameter int SCAN_DIV = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    draw_req,
   input  logic [LW-1:0]           snake_len,
   input  logic [MAX_LEN*2*CW-1:0] snake_flat,
   input  logic [2*CW-1:0]         food,
   input  logic                    food_en,
   input  logic [1:0]              mode,
   output logic                    busy,
   output logic                    frame_done,
   output logic [GRID-1:0]         row_sel,
   output logic [GRID-1:0]         row_data
);

   localparam int SW = 2 * CW;

   draw_state_t state, state_nx;

   logic [GRID-1:0]       front [GRID];
   logic [GRID-1:0]       back  [GRID];
   logic [MAX_LEN*SW-1:0] lat_flat;
   logic [SW-1:0]         lat_food;
   logic                  lat_food_en;
   logic [LW-1:0]         lat_len;
   logic                  pending;
   logic                  start;
   logic [CW-1:0]         clr_row;
   logic [LW-1:0]         seg_idx;
   logic [CW-1:0]         row_idx;
   logic [SW-1:0]         seg_coord;
   logic [SW-1:0]         draw_coord;
   logic [CW-1:0]         draw_r;
   logic [CW-1:0]         draw_c;
   logic [GRID-1:0]       pattern;

   // ---------------- draw FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (draw_req || pending) begin
               start    = 1'b1;
               state_nx = ST_CLEAR;
            end
         end
         ST_CLEAR: if (clr_row == CW'(GRID - 1)) state_nx = ST_FOOD;
         ST_FOOD:  state_nx = (lat_len == '0) ? ST_SWAP : ST_SEG;
         ST_SEG:   if (seg_idx == lat_len - LW'(1)) state_nx = ST_SWAP;
         ST_SWAP:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   assign busy       = (state != ST_IDLE);
   assign frame_done = (state == ST_SWAP);

   // Food is drawn in FOOD, segments in SEG; both share one pixel decoder.
   assign seg_coord  = lat_flat[seg_idx*SW +: SW];
   assign draw_coord = (state == ST_FOOD) ? lat_food : seg_coord;
   assign draw_r     = CW'(coord_row((2*MAX_CW)'(draw_coord), CW));
   assign draw_c     = CW'(coord_col((2*MAX_CW)'(draw_coord), CW));

   // ---------------- buffers and draw datapath ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: buffers are flops, not RAM, because reset must blank them in one cycle.
         for (int r = 0; r < GRID; r++) begin
            front[r] <= '0;
            back[r]  <= '0;
         end
         lat_flat    <= '0;
         lat_food    <= '0;
         lat_food_en <= 1'b0;
         lat_len     <= '0;
         pending     <= 1'b0;
         clr_row     <= '0;
         seg_idx     <= '0;
      end else begin
         if (busy && draw_req) pending <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  lat_flat    <= snake_flat;
                  lat_food    <= food;
                  lat_food_en <= food_en;
                  lat_len     <= (snake_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : snake_len;
                  pending     <= 1'b0;
                  clr_row     <= '0;
               end
            end
            ST_CLEAR: begin
               back[clr_row] <= '0;
               clr_row       <= clr_row + CW'(1);
            end
            ST_FOOD: begin
               if (lat_food_en) back[draw_r][draw_c] <= 1'b1;
               seg_idx <= '0;
            end
            ST_SEG: begin
               back[draw_r][draw_c] <= 1'b1;
               seg_idx              <= seg_idx + LW'(1);
            end
            ST_SWAP: begin
               for (int r = 0; r < GRID; r++) front[r] <= back[r];
            end
            default: ;
         endcase
      end
   end

   // ---------------- scan output ----------------
   led_row_scanner #(
      .GRID     (GRID),
      .CW       (CW),
      .SCAN_DIV (SCAN_DIV)
   ) u_scanner (
      .clk     (clk),
      .reset   (reset),
      .row_idx (row_idx),
      .row_sel (row_sel)
   );

   always_comb begin
      pattern = '0;
      case (mode)
         MODE_GAME:  pattern = front[row_idx];
         MODE_START: begin
            if (row_idx == '0 || row_idx == CW'(GRID - 1)) pattern = '1;
            else pattern = {1'b1, {(GRID-2){1'b0}}, 1'b1};
         end
         MODE_OVER:  pattern = (GRID'(1) << row_idx) | (GRID'(1) << (CW'(GRID - 1) - row_idx));
         MODE_WIN:   pattern = '1;
         default:    pattern = '1;
      endcase
   end

   // Registered alongside row_sel so strobe and data change on the same edge.
   always_ff @(posedge clk) begin
      if (reset) row_data <= '0;
      else       row_data <= pattern;
   end

endmodule

// File: tb/tb_snake_frame_renderer.sv
// Scoreboard bench for snake_frame_renderer: frame expectations are queued at
// launch and compared on frame_done, then the scanned image is checked row by row.
module tb_snake_frame_renderer;

   localparam int GRID     = 16;
   localparam int CW       = 4;
   localparam int MAX_LEN  = 10;
   localparam int LW       = 4;
   localparam int SCAN_DIV = 4;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    draw_req;
   logic [LW-1:0]           snake_len;
   logic [MAX_LEN*2*CW-1:0] snake_flat;
   logic [2*CW-1:0]         food;
   logic                    food_en;
   logic [1:0]              mode;
   logic                    busy;
   logic                    frame_done;
   logic [GRID-1:0]         row_sel;
   logic [GRID-1:0]         row_data;

   always #5 clk = ~clk;

   snake_frame_renderer #(
      .GRID(GRID), .CW(CW), .MAX_LEN(MAX_LEN), .LW(LW), .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .draw_req   (draw_req),
      .snake_len  (snake_len),
      .snake_flat (snake_flat),
      .food       (food),
      .food_en    (food_en),
      .mode       (mode),
      .busy       (busy),
      .frame_done (frame_done),
      .row_sel    (row_sel),
      .row_data   (row_data)
   );

   typedef struct {
      int           lat;
      logic [255:0] img;
   } exp_t;

   exp_t         sb[$];
   int           n_checks = 0;
   int           n_pass   = 0;
   int           cyc = 0, busy_cycles = 0, n_done = 0;
   int           done_cyc, done_busy;
   logic [7:0]   seg_buf [MAX_LEN];
   logic [255:0] front_model;
   logic [15:0]  cap [GRID];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (busy)       busy_cycles <= busy_cycles + 1;
      if (frame_done) n_done      <= n_done + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [79:0] pack_segs();
      logic [79:0] flat;
      for (int i = 0; i < MAX_LEN; i++) flat[i*8 +: 8] = seg_buf[i];
      return flat;
   endfunction

   function automatic logic [255:0] model_img(input int len_in, input logic [7:0] f,
                                              input logic fen);
      logic [255:0] img;
      int n;
      n   = (len_in > MAX_LEN) ? MAX_LEN : len_in;
      img = '0;
      if (fen) img[f[7:4]*16 + f[3:0]] = 1'b1;
      for (int i = 0; i < n; i++) img[seg_buf[i][7:4]*16 + seg_buf[i][3:0]] = 1'b1;
      return img;
   endfunction

   function automatic logic [15:0] exp_row(input logic [1:0] m, input int r);
      case (m)
         2'b00:   return front_model[r*16 +: 16];
         2'b01:   return (r == 0 || r == 15) ? 16'hFFFF : 16'h8001;
         2'b10:   return (16'h1 << r) | (16'h1 << (15 - r));
         default: return 16'hFFFF;
      endcase
   endfunction

   function automatic int row_of();
      for (int i = 0; i < GRID; i++) if (row_sel == (16'h1 << i)) return i;
      return -1;
   endfunction

   // Drive a frame's inputs with draw_req high and queue what it must produce.
   task automatic launch(input logic [LW-1:0] len, input logic [7:0] f, input logic fen);
      exp_t e;
      snake_len  = len;
      snake_flat = pack_segs();
      food       = f;
      food_en    = fen;
      draw_req   = 1'b1;
      e.img = model_img(int'(len), f, fen);
      e.lat = GRID + ((int'(len) > MAX_LEN) ? MAX_LEN : int'(len)) + 2;
      sb.push_back(e);
   endtask

   task automatic wait_frame(input string tag, input int t_ref, input int b_ref);
      exp_t e;
      int   k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!frame_done && k < 200);
      check({tag, "_done_seen"}, frame_done, 1'b1);
      if (!frame_done) return;
      check({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check({tag, "_latency"}, cyc - t_ref, e.lat);
      front_model = e.img;
      @(negedge clk);
      check({tag, "_pulse"}, frame_done, 1'b0);
      check({tag, "_busy_cycles"}, busy_cycles - b_ref, e.lat);
      done_cyc  = cyc;
      done_busy = busy_cycles;
   endtask

   task automatic capture_frame(input string tag, input int budget, input bit must_complete);
      logic [15:0] seen = '0;
      int r;
      int k = 0;
      while (seen != 16'hFFFF && k < budget) begin
         @(negedge clk);
         k++;
         r = row_of();
         if (r >= 0 && !seen[r]) begin
            seen[r] = 1'b1;
            cap[r]  = row_data;
            check($sformatf("%s_row%0d", tag, r), row_data, exp_row(mode, r));
         end
      end
      if (must_complete) check({tag, "_allrows"}, seen, 16'hFFFF);
   endtask

   task automatic run_frame(input string tag, input logic [LW-1:0] len, input logic [7:0] f,
                            input logic fen);
      int t0, b0;
      launch(len, f, fen);
      t0 = cyc;
      b0 = busy_cycles;
      @(negedge clk);
      draw_req = 1'b0;
      wait_frame(tag, t0, b0);
      capture_frame(tag, 100, 1'b1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] acc;
      int          busy_seen, t0, b0, nd0, r;

      reset = 1'b1; draw_req = 1'b0; snake_len = '0; snake_flat = '0;
      food = '0; food_en = 1'b0; mode = 2'b00; front_model = '0;
      for (int i = 0; i < MAX_LEN; i++) seg_buf[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_row_sel", row_sel, 16'h0);
      check("rst_row_data", row_data, 16'h0);

      // Idle scan: row k-1/SCAN_DIV shown at the k-th sample after release.
      reset = 1'b0;
      acc = '0;
      busy_seen = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         check($sformatf("idle_sel%0d", k), row_sel, 16'h1 << (((k - 1) / SCAN_DIV) % GRID));
         acc |= row_data;
         busy_seen |= int'(busy);
      end
      check("idle_data", acc, 16'h0);
      check("idle_busy", busy_seen, 0);

      // Full-length snake along row 0 plus food at (5,5).
      for (int i = 0; i < MAX_LEN; i++) seg_buf[i] = 8'h0F - 8'(i);
      run_frame("f1", 4'd10, 8'h55, 1'b1);
      check("f1_row0", cap[0], 16'hFFC0);
      check("f1_row5", cap[5], 16'h0020);

      for (int i = 0; i < 4; i++) seg_buf[i] = 8'h07 - 8'(i);
      run_frame("f2", 4'd4, 8'h55, 1'b0);
      check("f2_row0", cap[0], 16'h00F0);
      check("f2_row5", cap[5], 16'h0000);

      // Held request with inputs changed mid-draw: latched frame A then one frame B.
      nd0 = n_done;
      for (int i = 0; i < MAX_LEN; i++) seg_buf[i] = {4'(i), 4'(i)};
      launch(4'd10, 8'hAA, 1'b1);
      t0 = cyc;
      b0 = busy_cycles;
      repeat (3) @(negedge clk);
      for (int i = 0; i < MAX_LEN; i++) seg_buf[i] = {4'(i + 6), 4'h0};
      launch(4'd10, 8'h50, 1'b1);
      repeat (2) @(negedge clk);
      draw_req = 1'b0;
      wait_frame("pendA", t0, b0);
      capture_frame("pendA", 20, 1'b0);
      wait_frame("pendB", done_cyc, done_busy);
      capture_frame("pendB", 100, 1'b1);
      repeat (40) @(negedge clk);
      check("pend_done_count", n_done - nd0, 2);
      check("pend_idle", busy, 1'b0);

      for (int i = 0; i < MAX_LEN; i++) seg_buf[i] = 8'h0F - 8'(i);
      run_frame("clamp", 4'd15, 8'h55, 1'b1);

      run_frame("len0", 4'd0, 8'h00, 1'b1);
      check("len0_row0", cap[0], 16'h0001);

      // Overlays: the new mode must show on the very next sample.
      mode = 2'b11;
      @(negedge clk);
      r = row_of();
      check("win_next_onehot", (r >= 0), 1'b1);
      check("win_next", row_data, exp_row(2'b11, (r < 0) ? 0 : r));
      capture_frame("win", 100, 1'b1);
      check("win_row5", cap[5], 16'hFFFF);
      mode = 2'b10;
      @(negedge clk);
      r = row_of();
      check("over_next", row_data, exp_row(2'b10, (r < 0) ? 0 : r));
      capture_frame("over", 100, 1'b1);
      check("over_row3", cap[3], 16'h1008);
      mode = 2'b01;
      @(negedge clk);
      r = row_of();
      check("start_next", row_data, exp_row(2'b01, (r < 0) ? 0 : r));
      capture_frame("start", 100, 1'b1);
      check("start_row0", cap[0], 16'hFFFF);
      check("start_row7", cap[7], 16'h8001);
      mode = 2'b00;
      @(negedge clk);

      // Reset in the middle of SEG aborts the frame and blanks the front buffer.
      for (int i = 0; i < MAX_LEN; i++) seg_buf[i] = 8'h0F - 8'(i);
      snake_len = 4'd10; snake_flat = pack_segs(); food = 8'h55; food_en = 1'b1;
      draw_req = 1'b1;
      @(negedge clk);
      draw_req = 1'b0;
      repeat (19) @(negedge clk);
      check("rstmid_pre_busy", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_frame_done", frame_done, 1'b0);
      check("rstmid_row_sel", row_sel, 16'h0);
      check("rstmid_row_data", row_data, 16'h0);
      reset = 1'b0;
      front_model = '0;
      nd0 = n_done;
      capture_frame("rstmid", 100, 1'b1);
      check("rstmid_no_done", n_done - nd0, 0);
      check("rstmid_idle", busy, 1'b0);
      check("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
